// File: rtl/cordic_sin.sv
// Pipelined rotation-mode CORDIC sine/cosine; one sample per clock, latency ITER+2 clocks, no backpressure.
// Define CORDIC_SIN_VALID_EN to add I_valid/O_valid, carried alongside the samples.
module cordic_sin #(
   parameter int ITER = 14,
   parameter int DW   = 18,
   parameter int ZW   = 19
) (
   input  logic        I_clk,
   input  logic        I_rst,
   input  logic [13:0] I_phase,
`ifdef CORDIC_SIN_VALID_EN
   input  logic        I_valid,
   output logic        O_valid,
`endif
   output logic [13:0] O_cos,
   output logic [13:0] O_sin
);

   // x0 = round(K * 8191 * 4) pre-scales the cordic gain away
   localparam logic signed [DW-1:0] X0    = DW'(19896);
   localparam logic signed [DW:0]   RND   = (DW+1)'(2);
   localparam logic signed [DW:0]   SAT_P = (DW+1)'(8191);

   // round(atan(2^-i) * 2^17 / (2*pi)); z carries 4 fraction bits below the phase LSB
   localparam int ATAN [16] = '{16384, 9672, 5110, 2594, 1302, 652, 326, 163,
                                81, 41, 20, 10, 5, 3, 1, 1};

   logic [12:0]           ph_a;
   logic                  quad;
   logic [12:0]           z_fold;
   logic signed [DW-1:0]  x_r [0:ITER];
   logic signed [DW-1:0]  y_r [0:ITER];
   logic signed [ZW-1:0]  z_r [0:ITER];
   logic [ITER:0]         neg_r;

   assign ph_a   = I_phase[12:0];
   assign quad   = ph_a[12] ^ ph_a[11];
   assign z_fold = quad ? (ph_a - 13'd4096) : ph_a;

   function automatic logic [13:0] fmt(input logic signed [DW-1:0] v, input logic n);
      logic signed [DW:0] r;
      r = ($signed({v[DW-1], v}) + RND) >>> 2;
      if (n) r = -r;
      if (r > SAT_P) r = SAT_P;
      else if (r < -SAT_P) r = -SAT_P;
      return r[13:0];
   endfunction

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         for (int i = 0; i <= ITER; i++) begin
            x_r[i] <= '0;
            y_r[i] <= '0;
            z_r[i] <= '0;
         end
         neg_r <= '0;
         O_cos <= '0;
         O_sin <= '0;
      end else begin
         x_r[0]   <= X0;
         y_r[0]   <= '0;
         z_r[0]   <= {{(ZW-17){z_fold[12]}}, z_fold, 4'b0000};
         neg_r[0] <= quad;
         for (int i = 0; i < ITER; i++) begin
            if (!z_r[i][ZW-1]) begin
               x_r[i+1] <= x_r[i] - (y_r[i] >>> i);
               y_r[i+1] <= y_r[i] + (x_r[i] >>> i);
               z_r[i+1] <= z_r[i] - ZW'(ATAN[i]);
            end else begin
               x_r[i+1] <= x_r[i] + (y_r[i] >>> i);
               y_r[i+1] <= y_r[i] - (x_r[i] >>> i);
               z_r[i+1] <= z_r[i] + ZW'(ATAN[i]);
            end
            neg_r[i+1] <= neg_r[i];
         end
         O_cos <= fmt(x_r[ITER], neg_r[ITER]);
         O_sin <= fmt(y_r[ITER], neg_r[ITER]);
      end
   end

`ifdef CORDIC_SIN_VALID_EN
   logic [ITER+1:0] vld_sr;

   always_ff @(posedge I_clk) begin
      if (I_rst) vld_sr <= '0;
      else       vld_sr <= {vld_sr[ITER:0], I_valid};
   end

   assign O_valid = vld_sr[ITER+1];
`endif

endmodule

// File: tb/tb_cordic_sin.sv
// Scoreboard bench for cordic_sin: expectations queued per driven phase, checked 16 clocks later.
module tb_cordic_sin;

   logic        I_clk = 1'b0;
   logic        I_rst = 1'b1;
   logic [13:0] I_phase = '0;
   logic [13:0] O_cos;
   logic [13:0] O_sin;
`ifdef CORDIC_SIN_VALID_EN
   logic        I_valid = 1'b0;
   logic        O_valid;
   bit          vld_next = 1'b0;
`endif

   typedef struct {
      bit zero;
      int c;
      int s;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;

   cordic_sin dut (
      .I_clk   (I_clk),
      .I_rst   (I_rst),
      .I_phase (I_phase),
`ifdef CORDIC_SIN_VALID_EN
      .I_valid (I_valid),
      .O_valid (O_valid),
`endif
      .O_cos   (O_cos),
      .O_sin   (O_sin)
   );

   always #5 I_clk = ~I_clk;

   function automatic int rnd(input real v);
      if (v >= 0.0) return $rtoi(v + 0.5);
      return -$rtoi(0.5 - v);
   endfunction

   function automatic exp_t model(input logic [13:0] p);
      exp_t e;
      real  ang;
      int   a;
      a   = int'(p[12:0]);
      ang = 2.0 * 3.14159265358979 * real'(a) / 8192.0;
      e.zero = 1'b0;
      e.c    = rnd(8191.0 * $cos(ang));
      e.s    = rnd(8191.0 * $sin(ang));
      return e;
   endfunction

   // One clock of stimulus; a reset cycle replaces the pending expectations by 16 zero outputs.
   task automatic step(input int ph, input bit rst);
      exp_t z;
      @(negedge I_clk);
      I_phase = 14'(ph);
      I_rst   = rst;
`ifdef CORDIC_SIN_VALID_EN
      I_valid  = vld_next;
      vld_next = 1'b0;
`endif
      if (rst) begin
         sb.delete();
         z.zero = 1'b1; z.c = 0; z.s = 0;
         repeat (16) sb.push_back(z);
      end else begin
         sb.push_back(model(14'(ph)));
      end
   endtask

   exp_t mon_e;
   int   mon_c;
   int   mon_s;

   always @(posedge I_clk) begin
      #1;
      if (sb.size() == 16) begin
         mon_e = sb.pop_front();
         mon_c = int'($signed(O_cos));
         mon_s = int'($signed(O_sin));
         n_vec += 2;
         if (mon_e.zero) begin
            if (O_cos !== 14'd0) begin
               n_bad++;
               $display("FAIL sb_zero_cos: got %0d required 0", mon_c);
            end
            if (O_sin !== 14'd0) begin
               n_bad++;
               $display("FAIL sb_zero_sin: got %0d required 0", mon_s);
            end
         end else begin
            if ($isunknown(O_cos) || mon_c - mon_e.c > 3 || mon_e.c - mon_c > 3) begin
               n_bad++;
               $display("FAIL sb_cos: got %0d required %0d +/-3", mon_c, mon_e.c);
            end
            if ($isunknown(O_sin) || mon_s - mon_e.s > 3 || mon_e.s - mon_s > 3) begin
               n_bad++;
               $display("FAIL sb_sin: got %0d required %0d +/-3", mon_s, mon_e.s);
            end
         end
         n_vec++;
         if (mon_c < -8191 || mon_s < -8191) begin
            n_bad++;
            $display("FAIL range: got cos %0d sin %0d required within +/-8191", mon_c, mon_s);
         end
      end
   end

   task automatic test_reset();
      step(0, 1'b1);
      step(0, 1'b0);
      n_vec++;
      if (O_cos !== 14'd0 || O_sin !== 14'd0) begin
         n_bad++;
         $display("FAIL reset_state: got cos %0d sin %0d required 0 0",
                  $signed(O_cos), $signed(O_sin));
      end
   endtask

   task automatic test_quadrants();
      int ph [5] = '{-1024, 0, 2048, 4096, -2048};
      int ec [5] = '{5792, 8191, 0, -8191, 0};
      int es [5] = '{-5792, 0, 8191, 0, -8191};
      int oc, os;
      for (int k = 0; k < 5; k++) begin
         repeat (17) step(ph[k], 1'b0);
         oc = int'($signed(O_cos));
         os = int'($signed(O_sin));
         n_vec++;
         if ($isunknown({O_cos, O_sin}) || oc - ec[k] > 3 || ec[k] - oc > 3 ||
             os - es[k] > 3 || es[k] - os > 3) begin
            n_bad++;
            $display("FAIL quadrant_%0d: got (%0d,%0d) required (%0d,%0d) +/-3",
                     ph[k], oc, os, ec[k], es[k]);
         end
      end
   endtask

   task automatic test_wrap();
      int pa [2] = '{-8192, 8191};
      int pb [2] = '{0, -1};
      logic [13:0] c0, s0;
      for (int k = 0; k < 2; k++) begin
         repeat (17) step(pa[k], 1'b0);
         c0 = O_cos;
         s0 = O_sin;
         repeat (17) step(pb[k], 1'b0);
         n_vec++;
         if (O_cos !== c0 || O_sin !== s0) begin
            n_bad++;
            $display("FAIL wrap_%0d_vs_%0d: got (%0d,%0d) required (%0d,%0d)",
                     pb[k], pa[k], $signed(O_cos), $signed(O_sin), $signed(c0), $signed(s0));
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int p = -8192; p < 8192; p++) step(p, 1'b0);
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 30; k++) step(k * 277 - 4000, 1'b0);
      step(1500, 1'b1);
      step(1234, 1'b0);
      n_vec++;
      if (O_cos !== 14'd0 || O_sin !== 14'd0) begin
         n_bad++;
         $display("FAIL reset_mid: got cos %0d sin %0d required 0 0",
                  $signed(O_cos), $signed(O_sin));
      end
      for (int k = 0; k < 40; k++) step(k * 613 - 7000, 1'b0);
   endtask

`ifdef CORDIC_SIN_VALID_EN
   task automatic test_valid();
      int first;
      int cnt;
      vld_next = 1'b1;
      step(300, 1'b0);
      first = -1;
      cnt   = 0;
      for (int n = 1; n <= 24; n++) begin
         step(300, 1'b0);
         if (O_valid !== 1'b0) begin
            cnt++;
            if (first < 0) first = n;
         end
      end
      n_vec++;
      if (first != 16 || cnt != 1) begin
         n_bad++;
         $display("FAIL valid_pulse: got first %0d count %0d required first 16 count 1", first, cnt);
      end
      vld_next = 1'b1;
      step(300, 1'b0);
      repeat (5) step(300, 1'b0);
      step(300, 1'b1);
      cnt = 0;
      for (int n = 0; n < 24; n++) begin
         step(300, 1'b0);
         if (O_valid !== 1'b0) cnt++;
      end
      n_vec++;
      if (cnt != 0) begin
         n_bad++;
         $display("FAIL valid_flush: got %0d high cycles required 0", cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_quadrants();
      test_wrap();
      test_back_to_back();
      test_reset_mid();
`ifdef CORDIC_SIN_VALID_EN
      test_valid();
`endif
      repeat (17) step(0, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
